// File: rtl/ir_cmd_scheduler.sv
// Round-robin key-to-NEC command scheduler feeding the ir_encoder valid/ready port.
// Issues a full frame on grant, then repeat frames at a fixed period while the key is held.
module ir_cmd_scheduler #(
  parameter int unsigned FRAME_PERIOD_CYC = 2700000,
  parameter logic [31:0] CODE0            = 32'b10011101011000100000011100000111,
  parameter logic [31:0] CODE1            = 32'b10011111011000000000011100000111,
  parameter logic [31:0] CODE2            = 32'b10011110011000010000011100000111,
  parameter logic [31:0] CODE3            = 32'b10011010011001010000011100000111,
  parameter bit          REPEAT_EN        = 1'b1
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [3:0]  btn_state,
  input  logic        enc_ready,
  output logic [31:0] cmd,
  output logic        valid,
  output logic        repeat_frame,
  output logic [1:0]  active_id,
  output logic        busy
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CMD_W   = 32;

  // Accept cycle plus the decision cycle account for the two missing counts.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(FRAME_PERIOD_CYC - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     gap_cnt, gap_cnt_d;
  logic [ID_W-1:0]      last_id, last_id_d;
  logic [NUM_REQ-1:0]   mask, mask_d;
  logic [CMD_W-1:0]     cmd_d;
  logic                 valid_d;
  logic                 repeat_d;
  logic [ID_W-1:0]      id_d;
  logic                 busy_d;

  logic [NUM_REQ-1:0]   req;
  logic                 grant_vld;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      idx;

  function automatic logic [CMD_W-1:0] code_of(input logic [ID_W-1:0] id);
    case (id)
      2'd0:    code_of = CODE0;
      2'd1:    code_of = CODE1;
      2'd2:    code_of = CODE2;
      default: code_of = CODE3;
    endcase
  endfunction

  // Round-robin pick starting one past the last served requester.
  always_comb begin
    req       = btn_state & ~mask;
    grant_vld = 1'b0;
    grant_id  = last_id;
    idx       = last_id;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = last_id + ID_W'(i);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    gap_cnt_d = gap_cnt;
    last_id_d = last_id;
    mask_d    = mask & btn_state;
    cmd_d     = cmd;
    valid_d   = valid;
    repeat_d  = repeat_frame;
    id_d      = active_id;

    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_d  = ISSUE;
          valid_d  = 1'b1;
          repeat_d = 1'b0;
          cmd_d    = code_of(grant_id);
          id_d     = grant_id;
          if (!REPEAT_EN) mask_d[grant_id] = 1'b1;
        end
      end

      ISSUE: begin
        if (enc_ready) begin
          state_d   = GAP;
          valid_d   = 1'b0;
          gap_cnt_d = GAP_LOAD;
          last_id_d = active_id;
        end
      end

      GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_d = gap_cnt - CNT_W'(1);
        end else if (enc_ready) begin
          if (REPEAT_EN && btn_state[active_id]) begin
            state_d  = ISSUE;
            valid_d  = 1'b1;
            repeat_d = 1'b1;
          end else if (grant_vld) begin
            state_d  = ISSUE;
            valid_d  = 1'b1;
            repeat_d = 1'b0;
            cmd_d    = code_of(grant_id);
            id_d     = grant_id;
            if (!REPEAT_EN) mask_d[grant_id] = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      last_id      <= ID_W'(NUM_REQ - 1);
      mask         <= '0;
      cmd          <= '0;
      valid        <= 1'b0;
      repeat_frame <= 1'b0;
      active_id    <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      gap_cnt      <= gap_cnt_d;
      last_id      <= last_id_d;
      mask         <= mask_d;
      cmd          <= cmd_d;
      valid        <= valid_d;
      repeat_frame <= repeat_d;
      active_id    <= id_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: doc/ir_cmd_scheduler.md
Name: ir_cmd_scheduler

Overview:
- Sits between the four debounced key lines and the ir_encoder valid/ready command port, on clk25.
- Picks one requester with round-robin arbitration and presents its 32-bit NEC command.
- While that key stays held, it schedules NEC repeat frames at a fixed frame period.
- The frame period also enforces the inter-frame gap, so no slow-clock strobing is needed.

Parameters:
- FRAME_PERIOD_CYC, 2700000: cycles from one frame acceptance to the earliest next issue (108 ms at 25 MHz). Legal range 2..2^24-1.
- CODE0, 32'b10011101011000100000011100000111: command for requester 0 (Right).
- CODE1, 32'b10011111011000000000011100000111: command for requester 1 (Up).
- CODE2, 32'b10011110011000010000011100000111: command for requester 2 (Down).
- CODE3, 32'b10011010011001010000011100000111: command for requester 3 (Left).
- REPEAT_EN, 1: 1 = issue repeat frames while the active key is held; 0 = one frame per press.

Ports:
- clk25  in  1  system clock, 25 MHz.
- rst  in  1  reset, asynchronous, active-high.
- btn_state  in  4  debounced key levels, 1 = held; already synchronous to clk25.
- enc_ready  in  1  encoder can accept a frame.
- cmd  out  32  command word to the encoder.
- valid  out  1  frame request; a transfer happens on any cycle where valid && enc_ready.
- repeat_frame  out  1  qualifies cmd: 1 = encoder sends an NEC repeat code, 0 = full frame.
- active_id  out  2  requester currently granted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous, with effect immediate even mid-frame or mid-gap:
  - state = IDLE; cmd = 0, valid = 0, repeat_frame = 0, busy = 0, active_id = 0.
  - Gap counter = 0; last_id = 3, so requester 0 has top priority at first grant.
- All outputs are registered.
- States:
  - IDLE: if btn_state != 0 in cycle N, grant by round-robin. In cycle N+1: valid = 1, cmd = CODEk, repeat_frame = 0, active_id = k, state = ISSUE. Otherwise stay in IDLE.
  - ISSUE: valid held at 1. cmd, repeat_frame and active_id are stable until accepted. Key changes during ISSUE are ignored. On a cycle with enc_ready = 1 (accept):
    - next cycle valid = 0;
    - gap counter loads FRAME_PERIOD_CYC-2;
    - last_id = active_id;
    - state = GAP.
  - GAP: counter decrements to 0 and saturates there. When counter == 0 and enc_ready == 1, decide in that cycle; if enc_ready == 0, wait.
- Decision rules, applied in priority order:
  1. REPEAT_EN == 1 and btn_state[active_id] == 1: re-issue with repeat_frame = 1 and cmd unchanged, so the next valid comes exactly FRAME_PERIOD_CYC cycles after the previous accept.
  2. Otherwise, if any key is held: new round-robin grant, full frame (repeat_frame = 0).
  3. Otherwise: go to IDLE; busy = 0 next cycle.
- Round-robin: search order starts at (last_id+1) mod 4 and wraps. The held active key always wins through the repeat rule, so rotation only happens on release.
- A key pressed and released entirely within ISSUE or GAP is not latched: level semantics, no event queue.
- With REPEAT_EN = 0, a still-held active key is masked from arbitration until it is released. That key's btn_state bit must be seen at 0 in at least one cycle before it can be granted again.
- Counter width: 24 bits. There is no wrap; it saturates at 0.

Test Plan (FRAME_PERIOD_CYC = 100, REPEAT_EN = 1 unless stated):
- Reset: assert rst mid-GAP with valid history → all outputs 0 in the same cycle. After release with btn_state = 0, busy stays 0.
- Single tap: btn_state = 0001 for 1 cycle, enc_ready = 1 → valid = 1 one cycle later for exactly 1 cycle, with cmd = CODE0 and repeat_frame = 0. No further frames; busy falls 100 cycles after accept.
- Hold with repeats: btn_state = 0010 held 350 cycles → full frame CODE1 at accept T. Repeat frames (repeat_frame = 1, cmd = CODE1) accepted at T+100, T+200 and T+300, then IDLE.
- Backpressure: enc_ready = 0 for 20 cycles while valid → valid, cmd and active_id are stable throughout; the accept happens on the first enc_ready = 1 cycle. Likewise, enc_ready = 0 when the gap expires delays the next issue until enc_ready = 1.
- Arbitration: btn_state = 0101 → id 0 granted. Drop bit 0 during GAP → next frame is CODE2 full (repeat_frame = 0). Then at the decision after releasing bit 2, with btn_state = 0011 and last_id = 2 → id 0 granted.
- REPEAT_EN = 0: hold 0001 for 400 cycles → exactly one CODE0 frame. Release, then press again → a second CODE0 frame.
